// File: rtl/aes128_shift_rows.sv
// ShiftRows / InvShiftRows stage: scatters the incoming SubBytes byte stream straight into its
// permuted slot in a 128-bit state register and pulses done_o once all 16 slots are filled.
module aes128_shift_rows #(
   parameter bit INVERSE = 1'b0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [7:0]   data_i,
   input  logic [3:0]   addr_i,
   input  logic         valid_i,
   input  logic         done_i,
   output logic [127:0] state_o,
   output logic         done_o,
   output logic         busy_o,
   output logic         err_o
);

   typedef enum logic [1:0] {StIdle, StCollect, StDone} st_e;

   st_e            st_q;
   logic [127:0]   state_q;
   logic [15:0]    mask_q;
   logic           err_q;

   logic [1:0]     src_row;
   logic [1:0]     src_col;
   logic [1:0]     dst_col;
   logic [3:0]     dst_idx;
   logic [15:0]    dst_onehot;
   logic [15:0]    mask_nxt;
   logic           dup_write;

   // Row index is preserved; only the column rotates, with 2-bit wrap-around.
   always_comb begin
      src_row    = addr_i[1:0];
      src_col    = addr_i[3:2];
      dst_col    = INVERSE ? (src_col + src_row) : (src_col - src_row);
      dst_idx    = {dst_col, src_row};
      dst_onehot = 16'h0001 << dst_idx;
      mask_nxt   = mask_q | (valid_i ? dst_onehot : 16'h0000);
      dup_write  = valid_i && ((mask_q & dst_onehot) != 16'h0000);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q    <= StIdle;
         state_q <= 128'h0;
         mask_q  <= 16'h0;
         err_q   <= 1'b0;
      end else begin
         unique case (st_q)
            StIdle: begin
               if (start_i) begin
                  st_q   <= StCollect;
                  mask_q <= 16'h0;
                  err_q  <= 1'b0;
               end
            end
            StCollect: begin
               if (start_i) begin
                  mask_q <= 16'h0;
                  err_q  <= 1'b0;
               end else begin
                  if (valid_i) begin
                     state_q[8*dst_idx +: 8] <= data_i;
                     mask_q                  <= mask_nxt;
                  end
                  // Completion takes priority so done_i alongside the last byte is legal.
                  if (mask_nxt == 16'hFFFF) begin
                     st_q <= StDone;
                     if (dup_write) err_q <= 1'b1;
                  end else if (done_i) begin
                     st_q  <= StIdle;
                     err_q <= 1'b1;
                  end else if (dup_write) begin
                     err_q <= 1'b1;
                  end
               end
            end
            StDone: begin
               if (start_i) begin
                  st_q   <= StCollect;
                  mask_q <= 16'h0;
                  err_q  <= 1'b0;
               end else begin
                  st_q <= StIdle;
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end

   assign state_o = state_q;
   assign done_o  = (st_q == StDone);
   assign busy_o  = (st_q == StCollect);
   assign err_o   = err_q;

endmodule

// File: doc/aes128_shift_rows.md
Name: aes128_shift_rows

Overview:
- Downstream consumer of the SubBytes byte stream (8-bit data, 4-bit address, valid, done).
- Captures each substituted byte straight into its ShiftRows-permuted position in a 128-bit state register. Once all 16 bytes have arrived, it presents the shifted state with a one-cycle done pulse for the MixColumns / AddRoundKey stage.
- With INVERSE=1 it applies InvShiftRows for the decrypt path.

Parameters:
- INVERSE, 0, 0 = forward ShiftRows (row r rotated left by r); 1 = InvShiftRows (row r rotated right by r).

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  begin (or restart) collection of a new 16-byte block
- data_i  input  8  substituted byte from upstream
- addr_i  input  4  source byte index k (state byte k = data[8k+:8]; row k%4, column k/4)
- valid_i  input  1  data_i/addr_i valid this cycle
- done_i  input  1  upstream end-of-block indication
- state_o  output  128  shifted state register, dest byte j at [8j+:8]
- done_o  output  1  one-cycle pulse: state_o complete and valid
- busy_o  output  1  high while in COLLECT
- err_o  output  1  sticky protocol error flag

Behaviour:
- Reset (rst_i=1 at edge): FSM to IDLE; state_o=128'h0, mask=16'h0, done_o=0, busy_o=0, err_o=0. Reset overrides all other inputs, including mid-collection.
- Destination mapping for source k (r=k%4, c=k/4):
  - INVERSE=0: j = r + 4*((c - r) mod 4).
  - INVERSE=1: j = r + 4*((c + r) mod 4).
  - All arithmetic is 2-bit wrap-around.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - valid_i and done_i are ignored.
  - start_i moves to COLLECT, clears mask and err_o. state_o is not cleared.
- COLLECT (busy_o=1):
  - Each valid_i cycle writes data_i into state_o byte j and sets mask[j].
  - Duplicate write (mask[j] already 1): byte is overwritten, err_o is set, collection continues.
  - When the mask including the current write becomes 16'hFFFF, go to DONE at that edge.
  - done_i sampled while the mask including the current write is not full: set err_o, go to IDLE, no done_o.
  - done_i in the same cycle as the completing write is legal (upstream asserts its done alongside the last byte).
- DONE:
  - done_o=1 for exactly this one cycle, then go to IDLE.
  - done_o is therefore high in the cycle after the 16th unique byte is sampled: one cycle of latency from the last byte.
- start_i is accepted in any state.
  - In COLLECT it restarts: mask and err_o cleared, partial bytes left in place and overwritten by the new block.
  - In DONE, done_o still pulses that cycle and the next state is COLLECT.
  - start_i with valid_i in the same cycle: start wins; the byte is dropped and the mask is cleared.
- state_o holds its value after DONE until bytes of the next block are written. It is meaningful only from done_o onward.
- err_o is cleared only by rst_i or start_i.
- Byte order within a block is arbitrary. Completion is purely mask-based, not count-based.

Test Plan:
- INVERSE=0, start, stream k=0..15 with data=k (one per cycle, done_i with k=15) -> done_o one cycle after k=15. state_o bytes j=0..15 = 00,05,0A,0F,04,09,0E,03,08,0D,02,07,0C,01,06,0B. err_o=0.
- INVERSE=1, same stream -> state_o bytes j=0..15 = 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03. done_o single pulse.
- Bytes sent in reverse order (k=15..0) with one-cycle gaps in valid_i -> same state_o as the first scenario. done_o one cycle after the last byte.
- Byte k=5 sent twice within 16 writes -> err_o=1, still 15 unique bytes so no done_o. Sending the missing byte then gives done_o with err_o still 1. The next start_i clears err_o.
- done_i after only 10 bytes -> err_o=1, busy_o falls next cycle, done_o never asserts.
- rst_i asserted after 8 bytes -> next cycle state_o=0, busy_o=0, done_o=0. A fresh full block afterwards completes normally.
